pila_parametrica: RTL and testbench

PILA_PARAMETRICA -- requirements
Module: pila_parametrica

---
 rtl/pila_parametrica.sv | 91 +++++++++
 tb/tb_pila_parametrica.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pila_parametrica.sv
// LIFO stack with push/pop/peek/flush and sticky error flags; reads land on dout one cycle after the request.
// No backpressure: a push to a full stack or an out-of-range read is dropped and latched in ovf/udf.
module pila_parametrica #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             isp,
  input  logic             dsp,
  input  logic             rsp,
  input  logic             clr,
  input  logic [AW-1:0]    off,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic [AW:0]      sp,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          do_swap, do_push, do_pop, do_peek, peek_ok;
  logic [AW-1:0] top_idx, peek_idx;

  assign full  = (sp == (AW+1)'(DEPTH));
  assign empty = (sp == '0);

  // When sp == DEPTH the low bits wrap to 0, so top_idx still lands on DEPTH-1.
  assign top_idx  = sp[AW-1:0] - AW'(1);
  assign peek_idx = top_idx - off;
  assign peek_ok  = ({1'b0, off} < sp);

  assign do_swap = isp & dsp;
  assign do_push = isp & ~dsp;
  assign do_pop  = dsp & ~isp;
  assign do_peek = rsp & ~isp & ~dsp;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp     <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      sp     <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      if (do_swap) begin
        // Empty stack: the pushed word passes straight through.
        dout   <= empty ? din : mem[top_idx];
        dvalid <= 1'b1;
      end else if (do_push) begin
        if (full) ovf <= 1'b1;
        else      sp  <= sp + (AW+1)'(1);
      end else if (do_pop) begin
        if (empty) begin
          udf <= 1'b1;
        end else begin
          dout   <= mem[top_idx];
          dvalid <= 1'b1;
          sp     <= sp - (AW+1)'(1);
        end
      end else if (do_peek) begin
        if (peek_ok) begin
          dout   <= mem[peek_idx];
          dvalid <= 1'b1;
        end else begin
          udf <= 1'b1;
        end
      end
    end
  end

  // Storage has no reset; contents survive clr by design.
  always_ff @(posedge clk) begin
    if (!reset && !clr) begin
      if (do_swap && !empty)      mem[top_idx]    <= din;
      else if (do_push && !full)  mem[sp[AW-1:0]] <= din;
    end
  end

endmodule

// File: tb/tb_pila_parametrica.sv
// Directed and randomized checks of pila_parametrica (WIDTH=8, DEPTH=4) against a queue-based stack model.
module tb_pila_parametrica;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset, isp, dsp, rsp, clr;
  logic [AW-1:0]    off;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dvalid, full, empty, ovf, udf;
  logic [AW:0]      sp;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: back of the queue is the top of the stack.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dvalid, m_ovf, m_udf;

  pila_parametrica #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .isp(isp), .dsp(dsp), .rsp(rsp), .clr(clr),
    .off(off), .din(din), .dout(dout), .dvalid(dvalid), .sp(sp),
    .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, c, i, d, p, input int o, input logic [WIDTH-1:0] dn);
    int n;
    n = mq.size();
    if (r) begin
      mq.delete(); m_dout = '0; m_dvalid = 0; m_ovf = 0; m_udf = 0;
    end else if (c) begin
      mq.delete(); m_dvalid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_dvalid = 0;
      if (i && d) begin
        if (n == 0) m_dout = dn;
        else begin m_dout = mq[n-1]; mq[n-1] = dn; end
        m_dvalid = 1;
      end else if (i) begin
        if (n == DEPTH) m_ovf = 1;
        else mq.push_back(dn);
      end else if (d) begin
        if (n == 0) m_udf = 1;
        else begin m_dout = mq.pop_back(); m_dvalid = 1; end
      end else if (p) begin
        if (o < n) begin m_dout = mq[n-1-o]; m_dvalid = 1; end
        else m_udf = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sp"},     32'(sp),     32'(mq.size()));
    chk({tag, ".full"},   32'(full),   32'(mq.size() == DEPTH));
    chk({tag, ".empty"},  32'(empty),  32'(mq.size() == 0));
    chk({tag, ".dvalid"}, 32'(dvalid), 32'(m_dvalid));
    chk({tag, ".dout"},   32'(dout),   32'(m_dout));
    chk({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
    chk({tag, ".udf"},    32'(udf),    32'(m_udf));
  endtask

  // One clock cycle: drive, clock, advance model, compare.
  task automatic op(input string tag, input logic r, c, i, d, p, input int o, input logic [WIDTH-1:0] dn);
    reset = r; clr = c; isp = i; dsp = d; rsp = p; off = AW'(o); din = dn;
    @(posedge clk);
    #1;
    model_step(r, c, i, d, p, o, dn);
    reset = 0; clr = 0; isp = 0; dsp = 0; rsp = 0; off = '0; din = '0;
    check_all(tag);
  endtask

  initial begin
    reset = 1; clr = 0; isp = 0; dsp = 0; rsp = 0; off = '0; din = '0;
    m_dout = '0; m_dvalid = 0; m_ovf = 0; m_udf = 0;
    #2;
    op("rst", 1, 0, 0, 0, 0, 0, 8'h00);
    chk("rst.empty_const", 32'(empty), 32'd1);

    // Fill, overflow, drain.
    op("push11", 0, 0, 1, 0, 0, 0, 8'h11);
    op("push22", 0, 0, 1, 0, 0, 0, 8'h22);
    op("push33", 0, 0, 1, 0, 0, 0, 8'h33);
    op("push44", 0, 0, 1, 0, 0, 0, 8'h44);
    chk("fill.full_const", 32'(full), 32'd1);
    op("push55_ovf", 0, 0, 1, 0, 0, 0, 8'h55);
    chk("ovf.const", 32'(ovf), 32'd1);
    op("pop1", 0, 0, 0, 1, 0, 0, 8'h00);
    chk("pop1.const", 32'(dout), 32'h44);
    op("pop2", 0, 0, 0, 1, 0, 0, 8'h00);
    op("pop3", 0, 0, 0, 1, 0, 0, 8'h00);
    op("pop4", 0, 0, 0, 1, 0, 0, 8'h00);
    chk("pop4.const", 32'(dout), 32'h11);

    // Underflow then flush.
    op("pop_empty", 0, 0, 0, 1, 0, 0, 8'h00);
    op("clr", 0, 1, 0, 0, 0, 0, 8'h00);
    chk("clr.udf_const", 32'(udf), 32'd0);

    // Peek.
    op("pushA1", 0, 0, 1, 0, 0, 0, 8'hA1);
    op("pushB2", 0, 0, 1, 0, 0, 0, 8'hB2);
    op("pushC3", 0, 0, 1, 0, 0, 0, 8'hC3);
    op("peek0", 0, 0, 0, 0, 1, 0, 8'h00);
    chk("peek0.const", 32'(dout), 32'hC3);
    op("peek2", 0, 0, 0, 0, 1, 2, 8'h00);
    chk("peek2.const", 32'(dout), 32'hA1);
    op("peek3_bad", 0, 0, 0, 0, 1, 3, 8'h00);
    op("idle", 0, 0, 0, 0, 0, 0, 8'h00);

    // Push+pop swap and empty bypass.
    op("clr2", 0, 1, 0, 0, 0, 0, 8'h00);
    op("push05", 0, 0, 1, 0, 0, 0, 8'h05);
    op("swap09", 0, 0, 1, 1, 0, 0, 8'h09);
    chk("swap.const", 32'(dout), 32'h05);
    op("pop09", 0, 0, 0, 1, 0, 0, 8'h00);
    chk("pop09.const", 32'(dout), 32'h09);
    op("bypass7E", 0, 0, 1, 1, 0, 0, 8'h7E);
    chk("bypass.const", 32'(dout), 32'h7E);

    // Swap while full must not flag overflow.
    for (int k = 0; k < DEPTH; k++) op("fill", 0, 0, 1, 0, 0, 0, WIDTH'(8'h60 + k));
    op("swap_full", 0, 0, 1, 1, 0, 0, 8'hEE);
    op("pop_after_swap", 0, 0, 0, 1, 0, 0, 8'h00);

    // Reset wins over a simultaneous push.
    op("clr3", 0, 1, 0, 0, 0, 0, 8'h00);
    op("pushR1", 0, 0, 1, 0, 0, 0, 8'h01);
    op("pushR2", 0, 0, 1, 0, 0, 0, 8'h02);
    op("rst_push", 1, 0, 1, 0, 0, 0, 8'h03);
    op("pop_after_rst", 0, 0, 0, 1, 0, 0, 8'h00);
    chk("rst_pop.udf_const", 32'(udf), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int sel;
      logic r, c, i, d, p;
      sel = int'($urandom_range(0, 99));
      r = (sel == 0);
      c = (sel >= 1 && sel <= 3);
      i = ($urandom_range(0, 99) < 45);
      d = ($urandom_range(0, 99) < 35);
      p = ($urandom_range(0, 99) < 40);
      op("rnd", r, c, i, d, p, int'($urandom_range(0, DEPTH-1)), WIDTH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
